// File: rtl/scan_select_sequencer.sv
// -----------------------------------------------------------------------------
// scan_select_sequencer
//
// Drives the select lines and enable of a 2-to-4 line decoder, stepping
// through slots 0 -> 1 -> 2 -> 3 -> 0. Each slot lasts PRESCALE clocks. The
// first BLANK clocks of every slot hold enable low so the previous load is
// dark before the next one lights, which avoids ghosting when the four loads
// are time-multiplexed.
//
// Optional feature (compile-time macro SCAN_SEQ_SKIP_EN):
//   When defined, a skip_mask port is added. Bit n = 1 removes slot n from
//   the scan order. With every bit set, no slot ever starts.
//
// Parameters:
//   PRESCALE    clocks per slot (1..255)
//   BLANK       clocks of enable=0 at the start of each slot (0..PRESCALE-1)
//   PRESCALE_W  width of the slot timer; must be able to hold PRESCALE-1
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   run         in   level; scan continuously while high
//   step        in   single-cycle pulse; runs one slot when idle
//   skip_mask   in   [3:0] slot skip bits (SCAN_SEQ_SKIP_EN only)
//   select1     out  slot MSB -> decoder input1
//   select0     out  slot LSB -> decoder input0
//   enable      out  decoder enable
//   slot_start  out  one-cycle pulse when a new slot's select is driven
//   busy        out  high while a slot is in progress (blanking or active)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module scan_select_sequencer #(
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned BLANK      = 1,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic       step,
`ifdef SCAN_SEQ_SKIP_EN
    input  logic [3:0] skip_mask,
`endif
    output logic       select1,
    output logic       select0,
    output logic       enable,
    output logic       slot_start,
    output logic       busy
);

    // Elaboration-time parameter legality check.
    if ((PRESCALE < 1) || (PRESCALE > 255) || (BLANK > PRESCALE - 1) ||
        (PRESCALE_W < 1) || (((PRESCALE - 1) >> PRESCALE_W) != 0)) begin : g_bad_params
        $fatal(1, "scan_select_sequencer: illegal parameters PRESCALE=%0d BLANK=%0d PRESCALE_W=%0d",
               PRESCALE, BLANK, PRESCALE_W);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ACTIVE
    } state_t;

    // Timer runs 0..PRESCALE-1 across the whole slot; blanking occupies
    // counts 0..BLANK-1 and the active window the remaining counts.
    localparam logic [PRESCALE_W-1:0] LAST_T     = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] BLANK_LAST = PRESCALE_W'((BLANK == 0) ? 0 : BLANK - 1);

    state_t                state_q, state_d;
    state_t                entry_state;
    logic [1:0]            slot_q, slot_d;
    logic [PRESCALE_W-1:0] timer_q, timer_d;
    logic [1:0]            sel_q, sel_d;
    logic                  slot_start_q, slot_start_d;
    logic                  enable_q, enable_d;
    logic                  busy_q, busy_d;

    // Candidate slots: the one to use when leaving IDLE, and the successor
    // of the current slot. *_ok is low when no unmasked slot exists.
    logic                  first_ok;
    logic [1:0]            first_slot;
    logic                  nxt_ok;
    logic [1:0]            nxt_slot;

    logic                  launch;
    logic [1:0]            launch_slot;

    assign entry_state = (BLANK == 0) ? S_ACTIVE : S_BLANK;

`ifdef SCAN_SEQ_SKIP_EN
    // Nearest unmasked slot after s in cyclic order; s itself is the last
    // candidate (offset 4). Iterating from the far end lets the nearest
    // candidate overwrite the result last. Returns {found, slot}.
    function automatic logic [2:0] next_free(input logic [1:0] s, input logic [3:0] m);
        logic [2:0] r;
        logic [1:0] c;
        r = '0;
        for (int unsigned i = 4; i >= 1; i--) begin
            c = s + 2'(i);
            if (!m[c]) begin
                r = {1'b1, c};
            end
        end
        return r;
    endfunction

    always_comb begin
        {nxt_ok, nxt_slot} = next_free(slot_q, skip_mask);
        if (skip_mask[slot_q]) begin
            first_ok   = nxt_ok;
            first_slot = nxt_slot;
        end else begin
            first_ok   = 1'b1;
            first_slot = slot_q;
        end
    end
`else
    always_comb begin
        nxt_ok     = 1'b1;
        nxt_slot   = slot_q + 2'd1;
        first_ok   = 1'b1;
        first_slot = slot_q;
    end
`endif

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        timer_d      = timer_q;
        sel_d        = sel_q;
        slot_start_d = 1'b0;
        launch       = 1'b0;
        launch_slot  = slot_q;

        case (state_q)
            S_IDLE: begin
                if ((run || step) && first_ok) begin
                    launch      = 1'b1;
                    launch_slot = first_slot;
                end
            end

            S_BLANK: begin
                timer_d = timer_q + PRESCALE_W'(1);
                if (timer_q == BLANK_LAST) begin
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (timer_q == LAST_T) begin
                    // Slot complete: advance S regardless of run, then either
                    // chain straight into the next slot or drop to IDLE.
                    timer_d = '0;
                    state_d = S_IDLE;
                    if (nxt_ok) begin
                        slot_d = nxt_slot;
                        if (run) begin
                            launch      = 1'b1;
                            launch_slot = nxt_slot;
                        end
                    end
                end else begin
                    timer_d = timer_q + PRESCALE_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        if (launch) begin
            slot_d       = launch_slot;
            sel_d        = launch_slot;
            slot_start_d = 1'b1;
            timer_d      = '0;
            state_d      = entry_state;
        end

        enable_d = (state_d == S_ACTIVE);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            timer_q      <= '0;
            sel_q        <= '0;
            slot_start_q <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            timer_q      <= timer_d;
            sel_q        <= sel_d;
            slot_start_q <= slot_start_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
        end
    end

    assign select1    = sel_q[1];
    assign select0    = sel_q[0];
    assign enable     = enable_q;
    assign slot_start = slot_start_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_select_sequencer
//
// Bench for scan_select_sequencer with PRESCALE=4, BLANK=1. Output vectors are
// compared as {select1, select0, enable, slot_start, busy}. The reference
// model tracks "slot in progress, clocks since it started, current slot" and
// derives the outputs from that position within the slot. Skip-mask tests
// are compiled in when SCAN_SEQ_SKIP_EN is defined.
// -----------------------------------------------------------------------------
module tb_scan_select_sequencer;

    localparam int PRESCALE = 4;
    localparam int BLANK    = 1;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       run     = 1'b0;
    logic       step    = 1'b0;
    logic [3:0] mask    = '0;
    logic       select1, select0, enable, slot_start, busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_active;
    int m_pos;
    int m_s;
    int m_sel;

    typedef struct {
        logic       run;
        logic       step;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[23];

    scan_select_sequencer #(
        .PRESCALE  (PRESCALE),
        .BLANK     (BLANK),
        .PRESCALE_W(8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (run),
        .step      (step),
`ifdef SCAN_SEQ_SKIP_EN
        .skip_mask (mask),
`endif
        .select1   (select1),
        .select0   (select0),
        .enable    (enable),
        .slot_start(slot_start),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] eff_mask();
`ifdef SCAN_SEQ_SKIP_EN
        return mask;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic int next_of(input int s, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            if (!m[(s + k) % 4]) return (s + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_s      = 0;
        m_sel    = 0;
    endtask

    task automatic model_start(input int s_in);
        logic [3:0] m;
        int         s;
        m = eff_mask();
        s = s_in;
        if (m == 4'hF) return;
        if (m[s]) s = next_of(s, m);
        m_s      = s;
        m_sel    = s;
        m_active = 1'b1;
        m_pos    = 0;
    endtask

    task automatic model_edge(input logic r, input logic st);
        int n;
        if (!m_active) begin
            if (r || st) model_start(m_s);
        end else begin
            m_pos++;
            if (m_pos == PRESCALE) begin
                m_active = 1'b0;
                n = next_of(m_s, eff_mask());
                if (n >= 0) m_s = n;
                if (r) model_start(m_s);
            end
        end
    endtask

    function automatic logic [4:0] model_out();
        logic [1:0] sel;
        sel = 2'(m_sel);
        return {sel, (m_active && m_pos >= BLANK), (m_active && m_pos == 0), m_active};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: {sel,en,start,busy} got %b_%b_%b_%b, expected %b_%b_%b_%b",
                     name, $time, act[4:3], act[2], act[1], act[0],
                     exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic tick(input logic r, input logic st);
        run  = r;
        step = st;
        @(posedge clock);
        model_edge(r, st);
        #1;
    endtask

    task automatic do_reset();
        run     = 1'b0;
        step    = 1'b0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic       r;
        logic       st;
        logic [4:0] outs;

        // Table: fresh from reset; step, ignored step, run drop mid-slot, resume.
        tbl[0]  = '{1'b0, 1'b1, 5'b00011};
        tbl[1]  = '{1'b0, 1'b0, 5'b00101};
        tbl[2]  = '{1'b0, 1'b1, 5'b00101};
        tbl[3]  = '{1'b0, 1'b0, 5'b00101};
        tbl[4]  = '{1'b0, 1'b0, 5'b00000};
        tbl[5]  = '{1'b0, 1'b1, 5'b01011};
        tbl[6]  = '{1'b0, 1'b0, 5'b01101};
        tbl[7]  = '{1'b0, 1'b0, 5'b01101};
        tbl[8]  = '{1'b1, 1'b0, 5'b01101};
        tbl[9]  = '{1'b1, 1'b0, 5'b10011};
        tbl[10] = '{1'b1, 1'b0, 5'b10101};
        tbl[11] = '{1'b0, 1'b0, 5'b10101};
        tbl[12] = '{1'b0, 1'b0, 5'b10101};
        tbl[13] = '{1'b0, 1'b0, 5'b10000};
        tbl[14] = '{1'b1, 1'b0, 5'b11011};
        tbl[15] = '{1'b1, 1'b0, 5'b11101};
        tbl[16] = '{1'b1, 1'b0, 5'b11101};
        tbl[17] = '{1'b1, 1'b0, 5'b11101};
        tbl[18] = '{1'b1, 1'b0, 5'b00011};
        tbl[19] = '{1'b0, 1'b0, 5'b00101};
        tbl[20] = '{1'b0, 1'b0, 5'b00101};
        tbl[21] = '{1'b0, 1'b0, 5'b00101};
        tbl[22] = '{1'b0, 1'b0, 5'b00000};

        model_reset();

        // Asynchronous reset: outputs clear before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("reset_async", {select1, select0, enable, slot_start, busy}, 5'b00000);
        @(posedge clock);
        #1;
        check("reset_held", {select1, select0, enable, slot_start, busy}, 5'b00000);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            check("idle_hold", {select1, select0, enable, slot_start, busy}, 5'b00000);
        end

        for (int i = 0; i < 23; i++) begin
            tick(tbl[i].run, tbl[i].step);
            check($sformatf("table[%0d]", i), {select1, select0, enable, slot_start, busy}, tbl[i].exp);
        end

        // Reset in the middle of slot 3's active window, then resume from slot 0.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, 1'b0);
            check("run_scan", {select1, select0, enable, slot_start, busy}, model_out());
        end
        check("pre_reset_active", {select1, select0, enable, slot_start, busy}, 5'b11101);
        #2 reset_n = 1'b0;
        #1;
        check("reset_mid_slot", {select1, select0, enable, slot_start, busy}, 5'b00000);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick(1'b1, 1'b0);
        check("resume_slot0", {select1, select0, enable, slot_start, busy}, 5'b00011);

`ifdef SCAN_SEQ_SKIP_EN
        // Skip slots 0 and 2, then mask everything mid-slot.
        do_reset();
        mask = 4'b0101;
        tick(1'b1, 1'b0);
        check("skip_first", {select1, select0, enable, slot_start, busy}, 5'b01011);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("skip_second", {select1, select0, enable, slot_start, busy}, 5'b11011);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("skip_wrap", {select1, select0, enable, slot_start, busy}, 5'b01011);
        mask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check("mask_all_slot_completes", {select1, select0, enable, slot_start, busy}, 5'b01101);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            check("mask_all_idle", {select1, select0, enable, slot_start, busy}, 5'b01000);
        end
        mask = 4'b0000;
`endif

        // Randomised run/step (and mask) against the reference model.
        do_reset();
        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) r = ~r;
            st = ($urandom_range(3) == 0);
`ifdef SCAN_SEQ_SKIP_EN
            if ($urandom_range(31) == 0) mask = 4'($urandom_range(15));
`endif
            tick(r, st);
            outs = {select1, select0, enable, slot_start, busy};
            check("random", outs, model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
